axi_write_arbiter: RTL and testbench
====================================

Name: axi_write_arbiter

Overview:
- Write-path controller for the two-master / multi-slave AXI interconnect. It arbitrates AW requests from M0 and M1 using round-robin priority and decodes the target slave from AWADDR.
- It sequences each transaction through the address, data and response phases. Its outputs are the write-state and AWID-control selects that steer the write address, write data and write response muxes.
- Only one write transaction is in flight at a time; there is no interleaving.

Parameters:
- S1_BASE, 16'h0001, AWADDR[31:16] value that selects S1.
- S2_BASE, 16'h0002, AWADDR[31:16] value that selects S2.
- S3_BASE, 16'h1000, AWADDR[31:16] value that selects S3.
- S4_LO, 16'h2000, lowest AWADDR[31:16] value that selects S4 (DRAM).
- S4_HI, 16'h201F, highest AWADDR[31:16] value that selects S4.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- AWVALID_M0, AWVALID_M1  in  1  address request from each master.
- AWADDR_M0, AWADDR_M1  in  32  write address.
- AWLEN_M0, AWLEN_M1  in  4  burst length minus 1.
- WVALID_M0, WVALID_M1  in  1  write data valid.
- WLAST_M0, WLAST_M1  in  1  last beat of burst.
- BREADY_M0, BREADY_M1  in  1  master ready to accept response.
- AWREADY_S1..S4, AWREADY_SD  in  1 each  slave address ready; SD is the default (decode-error) slave.
- WREADY_S1..S4, WREADY_SD  in  1 each  slave write ready.
- BVALID_S1..S4, BVALID_SD  in  1 each  slave response valid.
- Aibiter_Write_State_control  out  2  current state: 00 IDLE, 01 ADDR, 10 DATA, 11 RESP.
- Arbiter_AWID_control  out  4  route select: [3] master (0=M0, 1=M1), [2:0] slave (1..4 = S1..S4, 5 = default); 4'b0000 when idle.
- GRANT_M0, GRANT_M1  out  1  one-hot master grant, held from ADDR through RESP.
- LEN_ERR  out  1  one-cycle pulse when the WLAST beat count does not match the latched AWLEN.

Behaviour:
- Reset (asynchronous, takes effect at any time including mid-transaction):
  - state = IDLE, Arbiter_AWID_control = 0, GRANT_M0 = GRANT_M1 = 0, LEN_ERR = 0.
  - Priority pointer points to M0; beat counter = 0.
- Decode (pure function of the granted master's AWADDR[31:16]):
  - equals S1_BASE → 1; equals S2_BASE → 2; equals S3_BASE → 3.
  - in [S4_LO, S4_HI] → 4.
  - anything else, including the ROM region, → 5 (default slave). The default slave must still complete the full handshake.
- IDLE:
  - If any AWVALID is high, select the requester. When both are high, the pointer holder wins.
  - Latch master ID, decoded slave and AWLEN on the same clock edge; move to ADDR.
  - Grant and AWID_control become valid one cycle after AWVALID is first seen.
- ADDR:
  - Wait for AWVALID of the granted master AND AWREADY of the selected slave.
  - On that handshake: move to DATA, clear the beat counter, and set the pointer to the non-granted master.
  - If AWVALID drops, stay in ADDR; no timeout.
- DATA:
  - Each WVALID(granted master) & WREADY(selected slave) cycle increments the 4-bit beat counter.
  - On a handshake with WLAST=1: move to RESP. If counter != latched AWLEN, pulse LEN_ERR for that cycle; the transition still occurs.
  - Beats beyond 16 without WLAST wrap the counter modulo 16; no error is flagged until WLAST.
- RESP:
  - Wait for BVALID(selected slave) & BREADY(granted master).
  - On that handshake: move to IDLE, drop the grant, and return AWID_control to 0000 on the next cycle.
  - The earliest new grant is one cycle after returning to IDLE. Back-to-back transactions therefore incur one IDLE cycle.
- No preemption: requests arriving while busy are held by their masters and serviced in round-robin order.
- Ready/valid signals of non-selected slaves are ignored in every state.
- All outputs are registered except LEN_ERR, which is combinational on the final beat.

Test Plan:
- Single M0 write: AWADDR_M0=0x0001_0000, AWLEN=0, ready signals tied high → states 01,10,11,00; AWID_control=4'b0001; GRANT_M0 held 3 cycles; LEN_ERR=0.
- Simultaneous requests after reset: M0 addr 0x0002_0000, M1 addr 0x1000_0000 → M0 served first with 4'b0010, then M1 with 4'b1011. Repeat both requests → M0 served first again because the pointer returned to M0.
- Burst to DRAM: M1 at 0x2000_0040, AWLEN=3, WREADY_S4 toggling 1,0,1,0 → exactly 4 accepted beats, RESP entered after the 4th, LEN_ERR=0.
- Length mismatch: AWLEN=3 with WLAST on the 2nd beat → LEN_ERR pulses one cycle, state moves to RESP.
- Unmapped address 0x0000_1000 → AWID_control[2:0]=5; completes via the SD handshakes; S1..S4 ready/valid inputs have no effect.
- ARESETn asserted in DATA with WVALID high → all outputs go to reset values immediately; after release, the next request goes to M0 first.

Source files
------------

// File: rtl/axi_write_arbiter_if.sv
// Write-path handshake bundle between the two masters, the slaves and the
// write arbiter. The "slave" modport is the arbiter's view; the "master"
// modport is the side that drives the request/ready/valid traffic.
interface axi_write_arbiter_if;
    logic        AWVALID_M0, AWVALID_M1;
    logic [31:0] AWADDR_M0,  AWADDR_M1;
    logic [3:0]  AWLEN_M0,   AWLEN_M1;
    logic        WVALID_M0,  WVALID_M1;
    logic        WLAST_M0,   WLAST_M1;
    logic        BREADY_M0,  BREADY_M1;
    logic        AWREADY_S1, AWREADY_S2, AWREADY_S3, AWREADY_S4, AWREADY_SD;
    logic        WREADY_S1,  WREADY_S2,  WREADY_S3,  WREADY_S4,  WREADY_SD;
    logic        BVALID_S1,  BVALID_S2,  BVALID_S3,  BVALID_S4,  BVALID_SD;
    logic [1:0]  Aibiter_Write_State_control;
    logic [3:0]  Arbiter_AWID_control;
    logic        GRANT_M0, GRANT_M1;
    logic        LEN_ERR;

    modport slave (
        input  AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1, AWLEN_M0, AWLEN_M1,
               WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1, BREADY_M0, BREADY_M1,
               AWREADY_S1, AWREADY_S2, AWREADY_S3, AWREADY_S4, AWREADY_SD,
               WREADY_S1, WREADY_S2, WREADY_S3, WREADY_S4, WREADY_SD,
               BVALID_S1, BVALID_S2, BVALID_S3, BVALID_S4, BVALID_SD,
        output Aibiter_Write_State_control, Arbiter_AWID_control,
               GRANT_M0, GRANT_M1, LEN_ERR
    );

    modport master (
        output AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1, AWLEN_M0, AWLEN_M1,
               WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1, BREADY_M0, BREADY_M1,
               AWREADY_S1, AWREADY_S2, AWREADY_S3, AWREADY_S4, AWREADY_SD,
               WREADY_S1, WREADY_S2, WREADY_S3, WREADY_S4, WREADY_SD,
               BVALID_S1, BVALID_S2, BVALID_S3, BVALID_S4, BVALID_SD,
        input  Aibiter_Write_State_control, Arbiter_AWID_control,
               GRANT_M0, GRANT_M1, LEN_ERR
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-master write-path arbiter: round-robin AW arbitration, slave decode
// from AWADDR[31:16], and one-at-a-time sequencing through ADDR/DATA/RESP.
module axi_write_arbiter #(
    parameter logic [15:0] S1_BASE = 16'h0001,
    parameter logic [15:0] S2_BASE = 16'h0002,
    parameter logic [15:0] S3_BASE = 16'h1000,
    parameter logic [15:0] S4_LO   = 16'h2000,
    parameter logic [15:0] S4_HI   = 16'h201F
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_write_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t     state_q;
    logic       mst_q;      // granted master: 0 = M0, 1 = M1
    logic [2:0] slv_q;      // selected slave: 1..4 = S1..S4, 5 = default
    logic [3:0] len_q;
    logic [3:0] cnt_q;      // beats accepted so far in DATA
    logic       ptr_q;      // round-robin priority holder
    logic       gnt0_q, gnt1_q;
    logic [3:0] awid_q;

    logic       pick_d;
    logic [2:0] slv_d;
    logic [3:0] len_d;
    logic       awvalid_g, wvalid_g, wlast_g, bready_g;
    logic       awready_s, wready_s, bvalid_s;
    logic       aw_hs, w_hs, b_hs;
    logic       unused_addr_lo;

    function automatic logic [2:0] decode(input logic [15:0] a);
        if (a == S1_BASE)                 return 3'd1;
        else if (a == S2_BASE)            return 3'd2;
        else if (a == S3_BASE)            return 3'd3;
        else if (a >= S4_LO && a <= S4_HI) return 3'd4;
        else                              return 3'd5;
    endfunction

    // Pick the requester (pointer holder wins a tie) and decode its target
    always_comb begin
        pick_d = (bus.AWVALID_M0 && bus.AWVALID_M1) ? ptr_q : bus.AWVALID_M1;
        slv_d  = decode(pick_d ? bus.AWADDR_M1[31:16] : bus.AWADDR_M0[31:16]);
        len_d  = pick_d ? bus.AWLEN_M1 : bus.AWLEN_M0;
    end

    // Route the granted master's and the selected slave's handshake signals
    always_comb begin
        awvalid_g = mst_q ? bus.AWVALID_M1 : bus.AWVALID_M0;
        wvalid_g  = mst_q ? bus.WVALID_M1  : bus.WVALID_M0;
        wlast_g   = mst_q ? bus.WLAST_M1   : bus.WLAST_M0;
        bready_g  = mst_q ? bus.BREADY_M1  : bus.BREADY_M0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        case (slv_q)
            3'd1: begin awready_s = bus.AWREADY_S1; wready_s = bus.WREADY_S1; bvalid_s = bus.BVALID_S1; end
            3'd2: begin awready_s = bus.AWREADY_S2; wready_s = bus.WREADY_S2; bvalid_s = bus.BVALID_S2; end
            3'd3: begin awready_s = bus.AWREADY_S3; wready_s = bus.WREADY_S3; bvalid_s = bus.BVALID_S3; end
            3'd4: begin awready_s = bus.AWREADY_S4; wready_s = bus.WREADY_S4; bvalid_s = bus.BVALID_S4; end
            3'd5: begin awready_s = bus.AWREADY_SD; wready_s = bus.WREADY_SD; bvalid_s = bus.BVALID_SD; end
            default: ;
        endcase
        aw_hs = awvalid_g && awready_s;
        w_hs  = wvalid_g  && wready_s;
        b_hs  = bvalid_s  && bready_g;
    end

    // Transaction sequencer with registered grant and route select
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            mst_q   <= 1'b0;
            slv_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            awid_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.AWVALID_M0 || bus.AWVALID_M1) begin
                    mst_q   <= pick_d;
                    slv_q   <= slv_d;
                    len_q   <= len_d;
                    gnt0_q  <= ~pick_d;
                    gnt1_q  <= pick_d;
                    awid_q  <= {pick_d, slv_d};
                    state_q <= ADDR;
                end
                ADDR: if (aw_hs) begin
                    cnt_q   <= '0;
                    ptr_q   <= ~mst_q;
                    state_q <= DATA;
                end
                DATA: if (w_hs) begin
                    cnt_q <= cnt_q + 4'd1;
                    if (wlast_g) state_q <= RESP;
                end
                RESP: if (b_hs) begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    awid_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // cnt_q holds the beats before this one, so a correct final beat sees cnt_q == AWLEN
    assign bus.LEN_ERR = (state_q == DATA) && w_hs && wlast_g && (cnt_q != len_q);

    assign bus.Aibiter_Write_State_control = state_q;
    assign bus.Arbiter_AWID_control        = awid_q;
    assign bus.GRANT_M0                    = gnt0_q;
    assign bus.GRANT_M1                    = gnt1_q;

    assign unused_addr_lo = ^{bus.AWADDR_M0[15:0], bus.AWADDR_M1[15:0]};

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter with hand-computed expectations.
module tb_axi_write_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    axi_write_arbiter_if bus();

    axi_write_arbiter #(
        .S1_BASE(16'h0001), .S2_BASE(16'h0002), .S3_BASE(16'h1000),
        .S4_LO(16'h2000),   .S4_HI(16'h201F)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        check({tag, ".state"}, 4'(bus.Aibiter_Write_State_control), 4'(exp));
    endtask

    task automatic chk_out(input string tag, input logic [3:0] id, input logic g0,
                           input logic g1, input logic le);
        check({tag, ".awid"},   bus.Arbiter_AWID_control, id);
        check({tag, ".grant0"}, 4'(bus.GRANT_M0), 4'(g0));
        check({tag, ".grant1"}, 4'(bus.GRANT_M1), 4'(g1));
        check({tag, ".lenerr"}, 4'(bus.LEN_ERR),  4'(le));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.AWVALID_M0 = 0; bus.AWVALID_M1 = 0;
        bus.AWADDR_M0  = '0; bus.AWADDR_M1 = '0;
        bus.AWLEN_M0   = '0; bus.AWLEN_M1  = '0;
        bus.WVALID_M0  = 0; bus.WVALID_M1  = 0;
        bus.WLAST_M0   = 0; bus.WLAST_M1   = 0;
        bus.BREADY_M0  = 0; bus.BREADY_M1  = 0;
        bus.AWREADY_S1 = 0; bus.AWREADY_S2 = 0; bus.AWREADY_S3 = 0; bus.AWREADY_S4 = 0; bus.AWREADY_SD = 0;
        bus.WREADY_S1  = 0; bus.WREADY_S2  = 0; bus.WREADY_S3  = 0; bus.WREADY_S4  = 0; bus.WREADY_SD  = 0;
        bus.BVALID_S1  = 0; bus.BVALID_S2  = 0; bus.BVALID_S3  = 0; bus.BVALID_S4  = 0; bus.BVALID_SD  = 0;
    endtask

    task automatic all_ready();
        bus.AWREADY_S1 = 1; bus.AWREADY_S2 = 1; bus.AWREADY_S3 = 1; bus.AWREADY_S4 = 1; bus.AWREADY_SD = 1;
        bus.WREADY_S1  = 1; bus.WREADY_S2  = 1; bus.WREADY_S3  = 1; bus.WREADY_S4  = 1; bus.WREADY_SD  = 1;
        bus.BVALID_S1  = 1; bus.BVALID_S2  = 1; bus.BVALID_S3  = 1; bus.BVALID_S4  = 1; bus.BVALID_SD  = 1;
        bus.BREADY_M0  = 1; bus.BREADY_M1  = 1;
        bus.WVALID_M0  = 1; bus.WVALID_M1  = 1;
        bus.WLAST_M0   = 1; bus.WLAST_M1   = 1;
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        #1;
        rst_n = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        clear_inputs();
        #12;
        rst_n = 1;
        chk_state("reset", 2'b00);
        chk_out("reset", 4'h0, 0, 0, 0);

        // ---- single M0 write to S1, AWLEN=0, readies high
        bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0001_0000; bus.AWLEN_M0 = 4'd0;
        bus.AWREADY_S1 = 1; bus.WREADY_S1 = 1; bus.BVALID_S1 = 1; bus.BREADY_M0 = 1;
        bus.WVALID_M0 = 1; bus.WLAST_M0 = 1;
        tick();
        chk_state("single.addr", 2'b01);
        chk_out("single.addr", 4'h1, 1, 0, 0);
        tick();
        bus.AWVALID_M0 = 0;
        chk_state("single.data", 2'b10);
        chk_out("single.data", 4'h1, 1, 0, 0);
        tick();
        chk_state("single.resp", 2'b11);
        chk_out("single.resp", 4'h1, 1, 0, 0);
        tick();
        chk_state("single.idle", 2'b00);
        chk_out("single.idle", 4'h0, 0, 0, 0);

        // ---- simultaneous requests after reset: M0 (S2) then M1 (S3), then M0 again
        clear_inputs();
        reset_pulse();
        all_ready();
        bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0002_0000;
        bus.AWVALID_M1 = 1; bus.AWADDR_M1 = 32'h1000_0000;
        tick();
        chk_state("rr1.addr", 2'b01);
        chk_out("rr1.addr", 4'h2, 1, 0, 0);
        tick();
        bus.AWVALID_M0 = 0;
        tick();
        chk_state("rr1.resp", 2'b11);
        tick();
        chk_state("rr1.idle", 2'b00);
        chk_out("rr1.idle", 4'h0, 0, 0, 0);
        tick();
        chk_state("rr2.addr", 2'b01);
        chk_out("rr2.addr", 4'hB, 0, 1, 0);
        tick();
        bus.AWVALID_M1 = 0;
        chk_state("rr2.data", 2'b10);
        tick();
        tick();
        chk_state("rr2.idle", 2'b00);
        bus.AWVALID_M0 = 1; bus.AWVALID_M1 = 1;
        tick();
        chk_out("rr3.addr", 4'h2, 1, 0, 0);
        tick();
        bus.AWVALID_M0 = 0;
        tick();
        tick();
        bus.AWVALID_M1 = 0;
        chk_state("rr3.idle", 2'b00);

        // ---- M1 burst to DRAM, AWLEN=3, WREADY_S4 toggling
        clear_inputs();
        bus.AWVALID_M1 = 1; bus.AWADDR_M1 = 32'h2000_0040; bus.AWLEN_M1 = 4'd3;
        bus.AWREADY_S4 = 1; bus.BVALID_S4 = 1; bus.BREADY_M1 = 1;
        tick();
        chk_out("burst.addr", 4'hC, 0, 1, 0);
        tick();
        bus.AWVALID_M1 = 0;
        bus.WVALID_M1 = 1;
        for (int b = 0; b < 6; b++) begin
            bus.WREADY_S4 = (b % 2 == 0);
            bus.WLAST_M1  = (b == 5);
            tick();
            chk_state("burst.beat", 2'b10);
        end
        bus.WREADY_S4 = 1; bus.WLAST_M1 = 1;
        #1;
        check("burst.lastlenerr", 4'(bus.LEN_ERR), 4'h0);
        tick();
        chk_state("burst.resp", 2'b11);
        tick();
        chk_state("burst.idle", 2'b00);

        // ---- length mismatch: AWLEN=3, WLAST on 2nd beat
        clear_inputs();
        bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0001_0000; bus.AWLEN_M0 = 4'd3;
        bus.AWREADY_S1 = 1; bus.BREADY_M0 = 1;
        tick();
        tick();
        bus.AWVALID_M0 = 0;
        bus.WVALID_M0 = 1; bus.WREADY_S1 = 1;
        #1;
        check("lenerr.beat1", 4'(bus.LEN_ERR), 4'h0);
        tick();
        bus.WLAST_M0 = 1;
        #1;
        check("lenerr.pulse", 4'(bus.LEN_ERR), 4'h1);
        tick();
        chk_state("lenerr.resp", 2'b11);
        check("lenerr.cleared", 4'(bus.LEN_ERR), 4'h0);
        tick();
        chk_state("lenerr.holdresp", 2'b11);
        bus.BVALID_S1 = 1;
        tick();
        chk_state("lenerr.idle", 2'b00);

        // ---- unmapped address goes to default slave; S1..S4 ignored
        clear_inputs();
        all_ready();
        bus.AWREADY_SD = 0; bus.WREADY_SD = 0; bus.BVALID_SD = 0;
        bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0000_1000; bus.AWLEN_M0 = 4'd0;
        tick();
        chk_out("sd.addr", 4'h5, 1, 0, 0);
        tick();
        chk_state("sd.waitaw", 2'b01);
        bus.AWREADY_SD = 1;
        tick();
        bus.AWVALID_M0 = 0;
        chk_state("sd.data", 2'b10);
        tick();
        chk_state("sd.waitw", 2'b10);
        bus.WREADY_SD = 1;
        tick();
        chk_state("sd.resp", 2'b11);
        tick();
        chk_state("sd.waitb", 2'b11);
        bus.BVALID_SD = 1;
        tick();
        chk_state("sd.idle", 2'b00);

        // ---- async reset mid-DATA, then pointer back at M0
        clear_inputs();
        bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0002_0000;
        bus.AWREADY_S2 = 1;
        tick();
        tick();
        bus.AWVALID_M0 = 0;
        bus.WVALID_M0 = 1;
        chk_state("arst.data", 2'b10);
        #2;
        rst_n = 0;
        #1;
        chk_state("arst.state", 2'b00);
        chk_out("arst.outs", 4'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0002_0000;
        bus.AWVALID_M1 = 1; bus.AWADDR_M1 = 32'h1000_0000;
        tick();
        chk_out("arst.regrant", 4'h2, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
